// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, line levels and frame geometry.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   localparam logic        START_BIT            = 1'b0;
   localparam logic        STOP_BIT             = 1'b1;
   localparam int unsigned DATA_BITS            = 8;
   localparam int unsigned FRAMES_PER_WORD      = 2;
   localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

   // Byte idx of the word in transmit order; lsb_first selects which half goes out first.
   function automatic logic [7:0] word_byte(input logic [15:0] w, input logic idx,
                                            input logic lsb_first);
      return (idx ^ ~lsb_first) ? w[15:8] : w[7:0];
   endfunction

endpackage

// File: rtl/uart_word_tx_if.sv
// Core-side word handshake plus serial line of the 16-bit UART transmitter.
interface uart_word_tx_if;

   logic [15:0] data_send;
   logic        data_send_valid;
   logic        data_send_done;
   logic        tx_busy;
   logic        ser_out;

   modport master (output data_send, data_send_valid,
                   input  data_send_done, tx_busy, ser_out);
   modport slave  (input  data_send, data_send_valid,
                   output data_send_done, tx_busy, ser_out);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and ticks on the last count.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rstb,
   input  logic enable,
   output logic bit_tick
);

   localparam int unsigned    CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] r_cnt;
   logic          w_last;

   assign w_last   = (r_cnt == LAST);
   assign bit_tick = enable & w_last;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_cnt <= '0;
      end else if (!enable || w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_word_tx.sv
// 16-bit word transmitter: two back-to-back 8N1 frames per accepted word on a registered line.
module uart_word_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
   parameter bit          LSB_BYTE_FIRST = 1'b1
) (
   input  logic           clk,
   input  logic           rstb,
   uart_word_tx_if.slave  bus
);

   localparam int unsigned     BW       = $clog2(DATA_BITS);
   localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_BITS - 1);
   localparam logic            LAST_BYTE = 1'(FRAMES_PER_WORD - 1);

   tx_state_t     r_state,    w_state_nxt;
   logic [15:0]   r_word,     w_word_nxt;
   logic [7:0]    r_shift,    w_shift_nxt;
   logic [BW-1:0] r_bit_idx,  w_bit_idx_nxt;
   logic          r_byte_idx, w_byte_idx_nxt;
   logic          r_ser,      w_ser_nxt;
   logic          r_done,     w_done_nxt;
   logic          w_tick;
   logic          w_active;

   assign w_active = (r_state != IDLE);

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .rstb     (rstb),
      .enable   (w_active),
      .bit_tick (w_tick)
   );

   // The line register is loaded with the level of the state being entered,
   // so each bit appears on ser_out in the first cycle of its bit period.
   always_comb begin
      w_state_nxt    = r_state;
      w_word_nxt     = r_word;
      w_shift_nxt    = r_shift;
      w_bit_idx_nxt  = r_bit_idx;
      w_byte_idx_nxt = r_byte_idx;
      w_ser_nxt      = r_ser;
      w_done_nxt     = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_ser_nxt = STOP_BIT;
            if (bus.data_send_valid) begin
               w_state_nxt    = START;
               w_word_nxt     = bus.data_send;
               w_shift_nxt    = word_byte(bus.data_send, 1'b0, LSB_BYTE_FIRST);
               w_byte_idx_nxt = 1'b0;
               w_bit_idx_nxt  = '0;
               w_ser_nxt      = START_BIT;
            end
         end
         START: begin
            if (w_tick) begin
               w_state_nxt   = DATA;
               w_bit_idx_nxt = '0;
               w_ser_nxt     = r_shift[0];
            end
         end
         DATA: begin
            if (w_tick) begin
               if (r_bit_idx == LAST_BIT) begin
                  w_state_nxt = STOP;
                  w_ser_nxt   = STOP_BIT;
               end else begin
                  w_shift_nxt   = r_shift >> 1;
                  w_ser_nxt     = r_shift[1];
                  w_bit_idx_nxt = r_bit_idx + 1'b1;
               end
            end
         end
         STOP: begin
            if (w_tick) begin
               if (r_byte_idx != LAST_BYTE) begin
                  w_state_nxt    = START;
                  w_byte_idx_nxt = 1'b1;
                  w_shift_nxt    = word_byte(r_word, 1'b1, LSB_BYTE_FIRST);
                  w_ser_nxt      = START_BIT;
               end else begin
                  w_state_nxt = IDLE;
                  w_ser_nxt   = STOP_BIT;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_ser_nxt   = STOP_BIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_state    <= IDLE;
         r_word     <= '0;
         r_shift    <= '0;
         r_bit_idx  <= '0;
         r_byte_idx <= 1'b0;
         r_ser      <= STOP_BIT;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_word     <= w_word_nxt;
         r_shift    <= w_shift_nxt;
         r_bit_idx  <= w_bit_idx_nxt;
         r_byte_idx <= w_byte_idx_nxt;
         r_ser      <= w_ser_nxt;
         r_done     <= w_done_nxt;
      end
   end

   assign bus.ser_out        = r_ser;
   assign bus.data_send_done = r_done;
   assign bus.tx_busy        = w_active;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed and random bench for uart_word_tx: per-cycle line model plus a mid-bit sampling receiver.
module tb_uart_word_tx;

   localparam int unsigned CPB  = 4;
   localparam int unsigned NONE = 32'hFFFF_FFFF;
   localparam int unsigned NRND = 24;

   logic clk = 1'b0;
   logic rstb;
   always #5 clk = ~clk;

   uart_word_tx_if if_a ();
   uart_word_tx_if if_b ();

   uart_word_tx #(.CLKS_PER_BIT(CPB), .LSB_BYTE_FIRST(1'b1)) dut_a (
      .clk (clk), .rstb (rstb), .bus (if_a.slave));
   uart_word_tx #(.CLKS_PER_BIT(CPB), .LSB_BYTE_FIRST(1'b0)) dut_b (
      .clk (clk), .rstb (rstb), .bus (if_b.slave));

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned frame_err = 0;
   logic [7:0]  rxq_a[$];
   logic [7:0]  rxq_b[$];
   logic [7:0]  expq_a[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic line(input bit sel);
      return sel ? if_b.ser_out : if_a.ser_out;
   endfunction

   task automatic chk_outs(input bit sel, input string tag, input logic es, input logic eb,
                           input logic ed);
      chk({tag, "_ser"},  32'(line(sel)), 32'(es));
      chk({tag, "_busy"}, 32'(sel ? if_b.tx_busy : if_a.tx_busy), 32'(eb));
      chk({tag, "_done"}, 32'(sel ? if_b.data_send_done : if_a.data_send_done), 32'(ed));
   endtask

   task automatic drive(input bit sel, input logic v, input logic [15:0] d);
      if (sel) begin
         if_b.data_send_valid = v; if_b.data_send = d;
      end else begin
         if_a.data_send_valid = v; if_a.data_send = d;
      end
   endtask

   // Line level in each of the 20 bit periods of a word: start, 8 data LSB first, stop, twice.
   function automatic logic [19:0] model_bits(input logic [15:0] w, input bit lsb_first);
      logic [7:0] b0, b1;
      b0 = lsb_first ? w[7:0]  : w[15:8];
      b1 = lsb_first ? w[15:8] : w[7:0];
      return {1'b1, b1, 1'b0, 1'b1, b0, 1'b0};
   endfunction

   // Sends one word and checks every cycle through the done cycle; optionally chains the next word.
   task automatic run_word(input bit sel, input logic [15:0] w, input bit pre_driven,
                           input int unsigned inject_at, input bit chain,
                           input logic [15:0] next_w);
      logic [19:0] bits;
      bits = model_bits(w, !sel);
      if (!sel) begin
         expq_a.push_back(w[7:0]);
         expq_a.push_back(w[15:8]);
      end
      if (!pre_driven) begin
         @(negedge clk);
         drive(sel, 1'b1, w);
      end
      for (int unsigned i = 0; i < 20 * CPB; i++) begin
         @(negedge clk);
         if (i == 0)                  drive(sel, 1'b0, 16'($urandom));
         else if (i == inject_at)     drive(sel, 1'b1, 16'h0000);
         else if (i == inject_at + 1) drive(sel, 1'b0, 16'h0000);
         chk_outs(sel, "word", bits[i / CPB], 1'b1, 1'b0);
      end
      @(negedge clk);
      chk_outs(sel, "donecyc", 1'b1, 1'b0, 1'b1);
      if (chain) drive(sel, 1'b1, next_w);
      else       drive(sel, 1'b0, 16'h0000);
   endtask

   task automatic rx_frame(input bit sel, output logic [7:0] b, output bit ok);
      do @(negedge clk); while (line(sel) !== 1'b0 || rstb !== 1'b1);
      repeat (CPB / 2) @(negedge clk);
      ok = (line(sel) === 1'b0);
      for (int unsigned j = 0; j < 8; j++) begin
         repeat (CPB) @(negedge clk);
         b[j] = line(sel);
      end
      repeat (CPB) @(negedge clk);
      ok = ok && (line(sel) === 1'b1);
   endtask

   initial forever begin : rx_a
      logic [7:0] b;
      bit         ok;
      rx_frame(1'b0, b, ok);
      rxq_a.push_back(b);
      if (!ok) frame_err++;
   end

   initial forever begin : rx_b
      logic [7:0] b;
      bit         ok;
      rx_frame(1'b1, b, ok);
      rxq_b.push_back(b);
      if (!ok) frame_err++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [15:0] words[NRND];
      bit          chained;
      bit          nxt_chain;
      rstb = 1'b0;
      drive(1'b0, 1'b0, 16'h0000);
      drive(1'b1, 1'b0, 16'h0000);
      repeat (3) @(negedge clk);
      chk_outs(1'b0, "rst_a", 1'b1, 1'b0, 1'b0);
      chk_outs(1'b1, "rst_b", 1'b1, 1'b0, 1'b0);
      rstb = 1'b1;
      repeat (2) @(negedge clk);
      chk_outs(1'b0, "idle_a", 1'b1, 1'b0, 1'b0);

      run_word(1'b0, 16'hA55A, 1'b0, NONE, 1'b0, 16'h0000);

      run_word(1'b1, 16'h12F0, 1'b0, NONE, 1'b0, 16'h0000);
      chk("order_cnt", 32'(rxq_b.size()), 32'd2);
      if (rxq_b.size() == 2) begin
         chk("order_byte0", 32'(rxq_b[0]), 32'h12);
         chk("order_byte1", 32'(rxq_b[1]), 32'hF0);
      end

      run_word(1'b0, 16'hFFFF, 1'b0, 9, 1'b0, 16'h0000);
      for (int unsigned i = 0; i < 3 * CPB; i++) begin
         @(negedge clk);
         chk_outs(1'b0, "ignored", 1'b1, 1'b0, 1'b0);
      end

      run_word(1'b0, 16'h0F0F, 1'b0, NONE, 1'b1, 16'hF00F);
      run_word(1'b0, 16'hF00F, 1'b1, NONE, 1'b0, 16'h0000);

      foreach (words[n]) words[n] = 16'($urandom);
      chained = 1'b0;
      for (int unsigned n = 0; n < NRND; n++) begin
         nxt_chain = (n + 1 < NRND) && ($urandom_range(0, 1) == 1);
         run_word(1'b0, words[n], chained, NONE, nxt_chain,
                  (n + 1 < NRND) ? words[n + 1] : 16'h0000);
         chained = nxt_chain;
      end
      repeat (2) @(negedge clk);
      chk("loop_cnt", 32'(rxq_a.size()), 32'(expq_a.size()));
      for (int unsigned n = 0; n < expq_a.size() && n < rxq_a.size(); n++)
         chk("loop_byte", 32'(rxq_a[n]), 32'(expq_a[n]));
      chk("frame_err", frame_err, 0);

      // Reset in the middle of the first frame, while the line is low.
      begin : mid_reset
         logic [19:0] bits;
         bits = model_bits(16'hA55A, 1'b1);
         @(negedge clk);
         drive(1'b0, 1'b1, 16'hA55A);
         for (int unsigned i = 0; i < 26; i++) begin
            @(negedge clk);
            if (i == 0) drive(1'b0, 1'b0, 16'h0000);
            chk_outs(1'b0, "pre_rst", bits[i / CPB], 1'b1, 1'b0);
         end
         #2 rstb = 1'b0;
         #1 chk_outs(1'b0, "async_rst", 1'b1, 1'b0, 1'b0);
         for (int unsigned i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_outs(1'b0, "in_rst", 1'b1, 1'b0, 1'b0);
         end
      end
      rxq_a.delete();
      expq_a.delete();
      frame_err = 0;
      rstb = 1'b1;
      drive(1'b0, 1'b1, 16'h0001);
      run_word(1'b0, 16'h0001, 1'b1, NONE, 1'b0, 16'h0000);
      @(negedge clk);
      chk_outs(1'b0, "post_done", 1'b1, 1'b0, 1'b0);
      chk("post_cnt", 32'(rxq_a.size()), 32'd2);
      if (rxq_a.size() == 2) begin
         chk("post_lo", 32'(rxq_a[0]), 32'h01);
         chk("post_hi", 32'(rxq_a[1]), 32'h00);
      end
      chk("post_frame_err", frame_err, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
